m_muldiv: RTL and testbench

//  Iterative RV64M multiply/divide unit, the multi-cycle companion to the single-cycle integer ALU.

---
 rtl/m_muldiv_pkg.sv | 25 ++
 rtl/m_muldiv_step.sv | 39 +++
 rtl/m_muldiv.sv | 158 +++++++++++++++
 tb/tb_m_muldiv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/m_muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// Contents: FSM state encoding and the 4-bit {w, funct3} operation codes.
package m_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [3:0] MD_OP_MUL    = 4'b0000;
  localparam logic [3:0] MD_OP_MULH   = 4'b0001;
  localparam logic [3:0] MD_OP_MULHSU = 4'b0010;
  localparam logic [3:0] MD_OP_MULHU  = 4'b0011;
  localparam logic [3:0] MD_OP_DIV    = 4'b0100;
  localparam logic [3:0] MD_OP_DIVU   = 4'b0101;
  localparam logic [3:0] MD_OP_REM    = 4'b0110;
  localparam logic [3:0] MD_OP_REMU   = 4'b0111;
  localparam logic [3:0] MD_OP_MULW   = 4'b1000;
  localparam logic [3:0] MD_OP_DIVW   = 4'b1100;
  localparam logic [3:0] MD_OP_DIVUW  = 4'b1101;
  localparam logic [3:0] MD_OP_REMW   = 4'b1110;
  localparam logic [3:0] MD_OP_REMUW  = 4'b1111;

endpackage

// File: rtl/m_muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div    1     select restoring-divide step (1) or shift-add multiply step (0)
//   acc       XLEN  high half: partial product / partial remainder
//   lo        XLEN  low half: multiplier bits / dividend-then-quotient bits
//   m         XLEN  multiplicand or divisor magnitude
//   acc_next  XLEN  updated high half
//   lo_next   XLEN  updated low half
module m_muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic          ge;

  always_comb begin
    sum = {1'b0, acc} + (lo[0] ? {1'b0, m} : '0);
    sh  = {acc, lo[XLEN-1]};
    ge  = (sh >= {1'b0, m});
    if (is_div) begin
      // When the subtract succeeds the difference is below m, so the
      // truncated XLEN-bit subtraction already yields the exact remainder.
      acc_next = ge ? (sh[XLEN-1:0] - m) : sh[XLEN-1:0];
      lo_next  = {lo[XLEN-2:0], ge};
    end else begin
      acc_next = sum[XLEN:1];
      lo_next  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/m_muldiv.sv
// Iterative RV64M multiply/divide unit, one bit per cycle.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready while idle)
//   a_i, b_i, md_op_i            operands and {w, funct3} op, sampled only at accept
//   kill_i                       abandon any in-flight op, return to idle
//   resp_valid_o / resp_ready_i  response handshake
//   result_o                     result, held while waiting for resp_ready_i
//
// state   | meaning
// MD_IDLE | waiting for a request
// MD_CALC | iterating, one bit per cycle
// MD_DONE | result valid, waiting for consumer
module m_muldiv
  import m_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      md_op_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, lo_q, m_q, result_q;
  logic            is_div_q, is_w_q, is_rem_q, mul_hi_q, neg_q;
  logic [XLEN-1:0] acc_n, lo_n;

  // request decode
  logic            op_w, op_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special, accept;
  logic [2:0]      f3;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_sx, min_neg, spec_res;

  always_comb begin
    op_w    = md_op_i[3];
    f3      = md_op_i[2:0];
    op_div  = f3[2];
    a_sgn   = op_div ? ~f3[0] : (f3 != 3'b011);
    b_sgn   = op_div ? ~f3[0] : ~f3[1];
    a_sx    = op_w ? sx32(a_i[31:0]) : a_i;
    a_ext   = op_w ? {{(XLEN-32){a_sgn & a_i[31]}}, a_i[31:0]} : a_i;
    b_ext   = op_w ? {{(XLEN-32){b_sgn & b_i[31]}}, b_i[31:0]} : b_i;
    a_neg   = a_sgn & a_ext[XLEN-1];
    b_neg   = b_sgn & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_neg = op_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = ~f3[0] & (a_ext == min_neg) & (&b_ext);
    special = op_div & (b_zero | ovf);
    if (b_zero) spec_res = f3[1] ? a_sx : '1;
    else        spec_res = f3[1] ? '0 : a_sx;
    accept  = req_valid_i & (state_q == MD_IDLE) & ~kill_i;
  end

  m_muldiv_step #(.XLEN(XLEN)) muldiv_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .lo       (lo_q),
    .m        (m_q),
    .acc_next (acc_n),
    .lo_next  (lo_n)
  );

  // sign fix-up applied on the final iteration
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dval, dval_s, wide_res, fix_res;

  always_comb begin
    // W multiply: 32 right shifts leave the product in {acc[31:0], lo[63:32]}
    prod     = is_w_q ? (2*XLEN)'({acc_n[31:0], lo_n[XLEN-1:XLEN-32]}) : {acc_n, lo_n};
    prod_s   = neg_q ? -prod : prod;
    dval     = is_rem_q ? acc_n : lo_n;
    dval_s   = neg_q ? -dval : dval;
    if (is_div_q) wide_res = dval_s;
    else          wide_res = mul_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    fix_res  = is_w_q ? sx32(wide_res[31:0]) : wide_res;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      MD_IDLE: begin
        req_ready_o = 1'b1;
        if (accept) state_d = special ? MD_DONE : MD_CALC;
      end
      MD_CALC: if (cnt_q == CW'(1)) state_d = MD_DONE;
      MD_DONE: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (kill_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      result_q <= '0;
      is_div_q <= 1'b0;
      is_w_q   <= 1'b0;
      is_rem_q <= 1'b0;
      mul_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      is_div_q <= op_div;
      is_w_q   <= op_w;
      is_rem_q <= f3[1];
      mul_hi_q <= ~op_w & (f3 != 3'b000);
      neg_q    <= (op_div & f3[1]) ? a_neg : (a_neg ^ b_neg);
      acc_q    <= '0;
      if (op_div) begin
        // W dividend sits in the top half so 32 left shifts consume it
        lo_q <= op_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
        m_q  <= b_mag;
      end else begin
        lo_q <= b_mag;
        m_q  <= a_mag;
      end
      cnt_q <= special ? '0 : (op_w ? CW'(32) : CW'(XLEN));
      if (special) result_q <= spec_res;
    end else if (state_q == MD_CALC && !kill_i) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_q <= fix_res;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_m_muldiv.sv
// Self-checking bench for m_muldiv: directed vector table plus handshake,
// kill and reset sequences.
module tb_m_muldiv;
  import m_muldiv_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        req_ready, resp_valid;
  logic [63:0] result;

  always #5 clk = ~clk;

  m_muldiv #(.XLEN(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .a_i          (a),
    .b_i          (b),
    .md_op_i      (op),
    .kill_i       (kill),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] o, input logic [63:0] va, input logic [63:0] vb,
                     input logic [63:0] e, input int l);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a request and pass the accepting edge; returns in cycle 1.
  // Operand inputs are scrambled afterwards: they must be ignored.
  task automatic start(input logic [3:0] o, input logic [63:0] va, input logic [63:0] vb);
    int g = 0;
    while (!req_ready && g < 100) begin tick; g++; end
    if (!req_ready) chk("ready_before_issue", {63'b0, req_ready}, 64'd1);
    op = o; a = va; b = vb; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 4'($urandom);
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin tick; lat++; end
  endtask

  task automatic finish_resp;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [63:0] held;

    add(MD_OP_MUL,    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    add(MD_OP_MUL,    64'd3, 64'd5, 64'd15, 65);
    add(MD_OP_MULH,   '1, '1, 64'd0, 65);
    add(MD_OP_MULH,   64'h4000_0000_0000_0000, 64'd4, 64'd1, 65);
    add(MD_OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65);
    add(MD_OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add(MD_OP_MULHU,  '1, 64'h10, 64'hF, 65);
    add(MD_OP_MULHSU, '1, 64'd2, '1, 65);
    add(MD_OP_MULHSU, 64'h8000_0000_0000_0000, 64'd2, '1, 65);
    add(MD_OP_DIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add(MD_OP_REM,    -64'sd7, 64'd2, '1, 65);
    add(MD_OP_DIV,    64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add(MD_OP_REM,    64'd7, -64'sd2, 64'd1, 65);
    add(MD_OP_DIVU,   64'd100, 64'd7, 64'd14, 65);
    add(MD_OP_REMU,   64'd100, 64'd7, 64'd2, 65);
    add(MD_OP_DIVU,   '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    add(MD_OP_DIVU,   64'd7, 64'd0, '1, 1);
    add(MD_OP_REMU,   64'd7, 64'd0, 64'd7, 1);
    add(MD_OP_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    add(MD_OP_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1);
    add(MD_OP_DIVW,   64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
    add(MD_OP_REMW,   64'hDEAD_0000_0000_0005, 64'hABCD_0000_0000_0000, 64'd5, 1);
    add(MD_OP_MULW,   64'h0001_0000, 64'h0001_0000, 64'd0, 33);
    add(MD_OP_MULW,   64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    add(MD_OP_DIVUW,  64'hFFFF_FFFF, 64'd1, '1, 33);
    add(MD_OP_DIVUW,  64'h8000_0000, 64'd2, 64'h4000_0000, 33);
    add(MD_OP_DIVW,   64'h1234_5678_0000_0064, 64'd7, 64'd14, 33);
    add(MD_OP_REMW,   64'hFFFF_FFF9, 64'd2, '1, 33);
    add(MD_OP_REMUW,  64'h8000_0005, 64'h10, 64'd5, 33);

    repeat (3) tick;
    rst = 1'b0;
    chk("reset_req_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("reset_result", result, 64'd0);

    foreach (vecs[i]) begin
      start(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_resp(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      finish_resp;
    end

    // consumer stalls for 10 cycles: result held, unit not ready
    start(MD_OP_DIVU, 64'd100, 64'd7);
    wait_resp(lat);
    held = 64'd0;
    for (int k = 0; k < 10; k++) begin
      held = held | (result ^ 64'd14);
      if (!resp_valid || req_ready) held = held | 64'h8000_0000_0000_0000;
      tick;
    end
    chk("hold_stable", held, 64'd0);
    // handshake and new request in the same cycle: request not taken yet
    resp_ready = 1'b1;
    op = MD_OP_MUL; a = 64'd3; b = 64'd5; req_valid = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("no_same_cycle_accept", {62'b0, req_ready, resp_valid}, 64'b10);
    tick;
    req_valid = 1'b0;
    chk("accept_next_cycle", {63'b0, req_ready}, 64'd0);
    wait_resp(lat);
    chk("b2b_result", result, 64'd15);
    finish_resp;

    // kill at cycle 20 of a DIV: no response ever
    start(MD_OP_DIV, -64'sd7, 64'd2);
    repeat (19) tick;
    kill = 1'b1;
    tick;
    kill = 1'b0;
    chk("kill_calc_idle", {62'b0, req_ready, resp_valid}, 64'b10);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      if (resp_valid) seen++;
      tick;
    end
    chk("kill_no_response", 64'(seen), 64'd0);

    // kill together with a request in IDLE: not accepted
    op = MD_OP_DIV; a = 64'd9; b = 64'd3; req_valid = 1'b1; kill = 1'b1;
    tick;
    req_valid = 1'b0; kill = 1'b0;
    chk("kill_blocks_accept", {63'b0, req_ready}, 64'd1);

    // kill in DONE, even with resp_ready: response drops
    start(MD_OP_DIVU, 64'd7, 64'd0);
    chk("special_done", {63'b0, resp_valid}, 64'd1);
    kill = 1'b1; resp_ready = 1'b1;
    tick;
    kill = 1'b0; resp_ready = 1'b0;
    chk("kill_done_drop", {62'b0, req_ready, resp_valid}, 64'b10);

    // reset mid-CALC
    start(MD_OP_MUL, 64'd3, 64'd5);
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_ready", {62'b0, req_ready, resp_valid}, 64'b10);
    chk("rst_mid_result", result, 64'd0);
    start(MD_OP_MULHU, '1, '1);
    wait_resp(lat);
    chk("post_rst_latency", 64'(lat), 64'd65);
    chk("post_rst_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    finish_resp;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
